// File: rtl/serial_add_sub_unit_pkg.sv
// ----------------------------------------------------------------------------
// add_sub_pkg
//   Shared definitions for the digit-serial add/subtract unit.
//   state_t : controller states (IDLE, BUSY, DONE)
//   OP_ADD / OP_SUB : encodings of the operation select input
// ----------------------------------------------------------------------------
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : add_sub_pkg

// File: rtl/serial_add_sub_unit_if.sv
// ----------------------------------------------------------------------------
// serial_add_sub_unit_if
//   Request and result handshakes of the digit-serial add/subtract unit.
//   Request : start_valid / start_ready, operands a, b, op select sub, cin
//   Result  : res_valid / res_ready, result s, flags cout, ovf, zero, neg
//   master : producer of requests and consumer of results (the client)
//   slave  : the arithmetic unit itself
// ----------------------------------------------------------------------------
interface serial_add_sub_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output start_valid, a, b, sub, cin, res_ready,
        input  start_ready, res_valid, s, cout, ovf, zero, neg
    );

    modport slave (
        input  start_valid, a, b, sub, cin, res_ready,
        output start_ready, res_valid, s, cout, ovf, zero, neg
    );

endinterface : serial_add_sub_unit_if

// File: rtl/serial_add_sub_unit_digit_adder.sv
// ----------------------------------------------------------------------------
// full_adder  : one-bit adder cell (a, b, cin -> s, cout).
// digit_adder : combinational DIGIT-bit ripple adder built from full_adder.
//   a, b : DIGIT-bit addends     cin  : carry in
//   s    : DIGIT-bit sum         cout : carry out of the top bit
// ----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule : full_adder

module digit_adder #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);
    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[DIGIT];
endmodule : digit_adder

// File: rtl/serial_add_sub_unit.sv
// ----------------------------------------------------------------------------
// serial_add_sub_unit
//   Digit-serial add/subtract unit: one DIGIT-bit slice per clock through a
//   single digit_adder, NDIG = WIDTH/DIGIT cycles per operation.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_add_sub_unit_if
//           (request handshake with operands, result handshake with flags)
//   sub=0 computes a+b+cin, sub=1 computes a-b-cin (cin is a borrow-in).
// ----------------------------------------------------------------------------
module serial_add_sub_unit
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_add_sub_unit_if.slave  bus
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUSY = BUSY;
    localparam logic [1:0] ST_DONE = DONE;

    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_add_sub_unit: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
    end

    // Controller and datapath state
    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;       // operand A, shifted right per digit
    logic [WIDTH-1:0] b_q,      b_d;       // effective operand B, shifted right per digit
    logic [WIDTH-1:0] acc_q,    acc_d;     // partial result, filled from the top
    logic             carry_q,  carry_d;
    logic             zacc_q,   zacc_d;    // stays 1 while every digit sum so far is 0
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             a_sign_q, a_sign_d;
    logic             b_sign_q, b_sign_d;

    // Registered result and flags, updated only on the last BUSY edge
    logic [WIDTH-1:0] s_q,      s_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;
    logic             zero_q,   zero_d;
    logic             neg_q,    neg_d;

    // Effective operands at accept time
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Digit adder connections
    logic [DIGIT-1:0] dsum;
    logic             dcout;

    // Shifted versions; the extended vectors keep DIGIT == WIDTH legal
    logic [WIDTH+DIGIT-1:0] a_ext;
    logic [WIDTH+DIGIT-1:0] b_ext;
    logic [WIDTH+DIGIT-1:0] acc_ext;
    logic [WIDTH-1:0]       a_shift;
    logic [WIDTH-1:0]       b_shift;
    logic [WIDTH-1:0]       acc_shift;
    logic                   zacc_next;

    assign b_eff = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
    assign c_eff = bus.cin ^ bus.sub;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .cin  (carry_q),
        .s    (dsum),
        .cout (dcout)
    );

    assign a_ext     = {{DIGIT{1'b0}}, a_q};
    assign b_ext     = {{DIGIT{1'b0}}, b_q};
    assign acc_ext   = {dsum, acc_q};
    assign a_shift   = a_ext[WIDTH+DIGIT-1:DIGIT];
    assign b_shift   = b_ext[WIDTH+DIGIT-1:DIGIT];
    assign acc_shift = acc_ext[WIDTH+DIGIT-1:DIGIT];
    assign zacc_next = zacc_q & ~(|dsum);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        zacc_d   = zacc_q;
        cnt_d    = cnt_q;
        a_sign_d = a_sign_q;
        b_sign_d = b_sign_q;
        s_d      = s_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        neg_d    = neg_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_valid) begin
                    state_d  = ST_BUSY;
                    a_d      = bus.a;
                    b_d      = b_eff;
                    carry_d  = c_eff;
                    cnt_d    = '0;
                    zacc_d   = 1'b1;
                    a_sign_d = bus.a[WIDTH-1];
                    b_sign_d = b_eff[WIDTH-1];
                end
            end

            ST_BUSY: begin
                a_d     = a_shift;
                b_d     = b_shift;
                acc_d   = acc_shift;
                carry_d = dcout;
                zacc_d  = zacc_next;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    // Last digit: publish result and flags together
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    s_d     = acc_shift;
                    cout_d  = dcout;
                    zero_d  = zacc_next;
                    neg_d   = acc_shift[WIDTH-1];
                    ovf_d   = (a_sign_q == b_sign_q) && (acc_shift[WIDTH-1] != a_sign_q);
                end
            end

            ST_DONE: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            cnt_q    <= '0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            s_q      <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            zacc_q   <= zacc_d;
            cnt_q    <= cnt_d;
            a_sign_q <= a_sign_d;
            b_sign_q <= b_sign_d;
            s_q      <= s_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

    assign bus.start_ready = (state_q == ST_IDLE);
    assign bus.res_valid   = (state_q == ST_DONE);
    assign bus.s           = s_q;
    assign bus.cout        = cout_q;
    assign bus.ovf         = ovf_q;
    assign bus.zero        = zero_q;
    assign bus.neg         = neg_q;

endmodule : serial_add_sub_unit

// File: tb/tb_serial_add_sub_unit.sv
// ----------------------------------------------------------------------------
// tb_serial_add_sub_unit
//   Bench for serial_add_sub_unit: a WIDTH=32/DIGIT=8 instance for the
//   directed table, backpressure, reset-abort and random operations, plus a
//   WIDTH=32/DIGIT=32 instance for the single-cycle configuration.
// ----------------------------------------------------------------------------
module tb_serial_add_sub_unit;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    serial_add_sub_unit_if #(.WIDTH(32)) if8  ();
    serial_add_sub_unit_if #(.WIDTH(32)) if32 ();

    serial_add_sub_unit #(.WIDTH(32), .DIGIT(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    serial_add_sub_unit #(.WIDTH(32), .DIGIT(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] exp_s;
        logic [3:0]  exp_flags;   // {cout, ovf, zero, neg}
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference arithmetic on the full word
    function automatic logic [35:0] golden(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub, input logic cin);
        logic [31:0] beff;
        logic        ceff;
        logic [32:0] r;
        logic        ovf;
        beff = sub ? ~b : b;
        ceff = cin ^ sub;
        r    = {1'b0, a} + {1'b0, beff} + {32'd0, ceff};
        ovf  = (a[31] == beff[31]) && (r[31] != a[31]);
        return {r[31:0], r[32], ovf, (r[31:0] == 32'd0), r[31]};
    endfunction

    // Issue one request on the DIGIT=8 unit and wait for its result
    task automatic start8(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic cin, output int lat);
        int n;
        @(negedge clk);
        if8.a = a; if8.b = b; if8.sub = sub; if8.cin = cin;
        if8.start_valid = 1'b1;
        n = 0;
        while (!if8.start_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL accept_timeout actual=no_accept expected=accept");
        end
        @(posedge clk);
        #1;
        if8.start_valid = 1'b0;
        lat = 0;
        while (!if8.res_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 100) begin
            errors++;
            $display("FAIL result_timeout actual=no_res_valid expected=res_valid");
        end
    endtask

    task automatic retire8();
        @(negedge clk);
        if8.res_ready = 1'b1;
        @(posedge clk);
        #1;
        if8.res_ready = 1'b0;
    endtask

    task automatic op8(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic cin, input int stall,
                       output logic [31:0] s, output logic [3:0] fl, output int lat);
        start8(a, b, sub, cin, lat);
        s  = if8.s;
        fl = {if8.cout, if8.ovf, if8.zero, if8.neg};
        for (int i = 0; i < stall; i++) @(posedge clk);
        retire8();
    endtask

    initial begin
        logic [31:0] s;
        logic [3:0]  fl;
        int          lat;
        logic [31:0] ra, rb;
        logic        rsub, rcin;
        logic [35:0] g;

        checks = 0;
        errors = 0;

        vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 4'b1010};
        vecs[1]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 4'b1100};
        vecs[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 4'b0001};
        vecs[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 4'b0101};
        vecs[4]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 4'b0000};
        vecs[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 4'b1010};
        vecs[6]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'b0001};
        vecs[7]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 4'b0000};
        vecs[8]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 4'b1110};
        vecs[9]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0001, 4'b0000};
        vecs[10] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 4'b1000};

        if8.start_valid  = 1'b0; if8.a  = '0; if8.b  = '0; if8.sub  = 1'b0; if8.cin  = 1'b0;
        if8.res_ready    = 1'b0;
        if32.start_valid = 1'b0; if32.a = '0; if32.b = '0; if32.sub = 1'b0; if32.cin = 1'b0;
        if32.res_ready   = 1'b0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state8", {31'd0, if8.start_ready, if8.res_valid, if8.s,
                             if8.cout, if8.ovf, if8.zero, if8.neg},
                            {31'd0, 1'b1, 1'b0, 32'd0, 4'b0000});
        chk("reset_state32", {31'd0, if32.start_ready, if32.res_valid, if32.s,
                              if32.cout, if32.ovf, if32.zero, if32.neg},
                             {31'd0, 1'b1, 1'b0, 32'd0, 4'b0000});
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, 0, s, fl, lat);
            chk($sformatf("vec%0d_s", i), {32'd0, s}, {32'd0, vecs[i].exp_s});
            chk($sformatf("vec%0d_flags", i), {60'd0, fl}, {60'd0, vecs[i].exp_flags});
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
        end

        // Backpressure: result held, new requests ignored
        start8(32'h1234_5678, 32'h0000_0001, 1'b0, 1'b0, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if8.start_valid = i[0];
            if8.a = 32'hDEAD_0000 + 32'(i);
            @(posedge clk);
            #1;
            chk($sformatf("hold_cycle%0d", i),
                {28'd0, if8.res_valid, if8.start_ready, if8.s, if8.cout, if8.ovf, if8.zero, if8.neg},
                {28'd0, 1'b1, 1'b0, 32'h1234_5679, 4'b0000});
        end
        @(negedge clk);
        if8.start_valid = 1'b0;
        retire8();
        chk("after_hold_idle", {62'd0, if8.start_ready, if8.res_valid}, {62'd0, 1'b1, 1'b0});

        // Reset during the second BUSY cycle aborts the operation
        @(negedge clk);
        if8.a = 32'h0102_0304; if8.b = 32'h1111_1111; if8.sub = 1'b0; if8.cin = 1'b0;
        if8.start_valid = 1'b1;
        @(posedge clk);
        #1;
        if8.start_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_state", {29'd0, if8.start_ready, if8.res_valid, if8.s, if8.cout, if8.ovf, if8.zero},
                           {29'd0, 1'b1, 1'b0, 32'd0, 3'b000});
        chk("abort_neg", {63'd0, if8.neg}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op8(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 0, s, fl, lat);
        chk("post_abort_s", {32'd0, s}, {32'd0, 32'h0000_0007});
        chk("post_abort_latency", 64'(lat), 64'd4);

        // Single-digit configuration
        @(negedge clk);
        if32.a = 32'h7FFF_FFFF; if32.b = 32'h0000_0001; if32.sub = 1'b0; if32.cin = 1'b0;
        if32.start_valid = 1'b1;
        @(posedge clk);
        #1;
        if32.start_valid = 1'b0;
        lat = 0;
        while (!if32.res_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("d32_latency", 64'(lat), 64'd1);
        chk("d32_s", {32'd0, if32.s}, {32'd0, 32'h8000_0000});
        chk("d32_flags", {60'd0, if32.cout, if32.ovf, if32.zero, if32.neg}, {60'd0, 4'b0101});
        @(negedge clk);
        if32.res_ready = 1'b1;
        @(posedge clk);
        #1;
        if32.res_ready = 1'b0;
        chk("d32_idle", {62'd0, if32.start_ready, if32.res_valid}, {62'd0, 1'b1, 1'b0});

        // Random operations with random result stalls
        for (int i = 0; i < 1000; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rsub = 1'($urandom_range(0, 1));
            rcin = 1'($urandom_range(0, 1));
            if (i % 10 == 0) rb = rsub ? ra : ~ra;
            g = golden(ra, rb, rsub, rcin);
            op8(ra, rb, rsub, rcin, int'($urandom_range(0, 3)), s, fl, lat);
            chk($sformatf("rand%0d a=%h b=%h sub=%0d cin=%0d", i, ra, rb, rsub, rcin),
                {28'd0, s, fl}, {28'd0, g});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case a wait never completes
    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_serial_add_sub_unit
